// File: rtl/tick_pkg.sv
// Shared constants and helpers for the tick scheduler (tick_sched, tick_div).
package tick_pkg;

   localparam int DEF_CLK_PER_TICK = 1000000;
   localparam int DEF_PW           = 8;

   // Index width that never collapses to zero bits for n <= 2.
   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_div.sv
// Base-tick divider: counts 0..CLK_PER_TICK-1 and flags the last count as tick.
module tick_div
   import tick_pkg::*;
#(
   parameter int CLK_PER_TICK = DEF_CLK_PER_TICK
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int            CW   = idx_w(CLK_PER_TICK);
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap;

   always_comb begin
      wrap  = (cnt_q == LAST);
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
   end

   // Gated with rst_n so tick stays low throughout reset.
   assign tick = wrap & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/tick_sched.sv
// Multi-channel periodic scheduler keyed on a base tick.
// Define TICK_SCHED_EXT_TICK_EN to take the tick from input ext_tick instead of tick_div.
module tick_sched
   import tick_pkg::*;
#(
   parameter int CLK_PER_TICK = DEF_CLK_PER_TICK,
   parameter int NCH          = 4,
   parameter int PW           = DEF_PW
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef TICK_SCHED_EXT_TICK_EN
   input  logic                  ext_tick,
`endif
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [idx_w(NCH)-1:0] ld_ch,
   input  logic [PW-1:0]         ld_period,
   output logic [NCH-1:0]        fire,
   output logic                  tick,
   output logic                  active
);

   localparam int CW = idx_w(NCH);

   logic [NCH-1:0][PW-1:0] per_q, per_d;
   logic [NCH-1:0][PW-1:0] cnt_q, cnt_d;
   logic [NCH-1:0]         fire_q, fire_d;
   logic                   active_q;
   logic                   ld_acc;

`ifdef TICK_SCHED_EXT_TICK_EN
   assign tick = ext_tick & rst_n;
`else
   tick_div #(
      .CLK_PER_TICK(CLK_PER_TICK)
   ) u_div (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );
`endif

   // Loads stall on the tick cycle so a load never races a countdown update.
   assign ld_ready = ~tick;
   assign ld_acc   = ld_valid & ld_ready;

   always_comb begin
      per_d  = per_q;
      cnt_d  = cnt_q;
      fire_d = '0;
      for (int i = 0; i < NCH; i++) begin
         if (ld_acc && (ld_ch == CW'(i))) begin
            per_d[i] = ld_period;
            cnt_d[i] = ld_period;
         end else if (tick && (per_q[i] != '0)) begin
            if (cnt_q[i] <= PW'(1)) begin
               cnt_d[i]  = per_q[i];
               fire_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] - PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_q    <= '0;
         cnt_q    <= '0;
         fire_q   <= '0;
         active_q <= 1'b0;
      end else begin
         per_q    <= per_d;
         cnt_q    <= cnt_d;
         fire_q   <= fire_d;
         active_q <= (per_q != '0);
      end
   end

   assign fire   = fire_q;
   assign active = active_q;

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched (CLK_PER_TICK=10, NCH=3); works with or without TICK_SCHED_EXT_TICK_EN.
module tb_tick_sched;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       ld_valid  = 1'b0;
   logic [1:0] ld_ch     = 2'd0;
   logic [7:0] ld_period = 8'd0;
   logic       ld_ready;
   logic [2:0] fire;
   logic       tick;
   logic       active;
`ifdef TICK_SCHED_EXT_TICK_EN
   logic       ext_tick  = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int k      = 0;
   int epoch  = 0;
   int xfers  = 0;
   int xbase  = 0;

   always #5 clk = ~clk;

   tick_sched #(
      .CLK_PER_TICK(10),
      .NCH         (3),
      .PW          (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef TICK_SCHED_EXT_TICK_EN
      .ext_tick (ext_tick),
`endif
      .ld_valid (ld_valid),
      .ld_ready (ld_ready),
      .ld_ch    (ld_ch),
      .ld_period(ld_period),
      .fire     (fire),
      .tick     (tick),
      .active   (active)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s k=%0d epoch=%0d got %0h want %0h", tag, k, epoch, obs, exp);
      end
   endtask

   // Hand-derived fire schedule, indexed by clocks since the last reset release.
   function automatic logic [2:0] exp_fire(input int e, input int kk);
      if (e == 0) begin
         case (kk)
            130, 160, 190, 370, 390: return 3'b001;
            220, 280:                return 3'b011;
            230, 270, 290:           return 3'b110;
            240, 260, 300:           return 3'b010;
            250:                     return 3'b111;
            default:                 return 3'b000;
         endcase
      end else begin
         case (kk)
            50, 60:  return 3'b001;
            default: return 3'b000;
         endcase
      end
   endfunction

   function automatic logic exp_act(input int e, input int kk);
      if (e == 0) return ((kk >= 104) && (kk <= 303)) || (kk >= 352);
      return (kk >= 42);
   endfunction

   task automatic chk_all();
      chk("tick", tick, (k % 10) == 9);
      chk("fire", fire, exp_fire(epoch, k));
      chk("active", active, exp_act(epoch, k));
   endtask

   task automatic step();
      if (ld_valid && ld_ready) xfers++;
      @(negedge clk);
      k++;
`ifdef TICK_SCHED_EXT_TICK_EN
      ext_tick = ((k % 10) == 9);
`endif
      chk_all();
   endtask

   task automatic run_to(input int n);
      while (k < n) step();
   endtask

   task automatic load(input logic [1:0] ch, input logic [7:0] p);
      ld_valid  = 1'b1;
      ld_ch     = ch;
      ld_period = p;
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      chk("rst_tick", tick, 1'b0);
      chk("rst_ready", ld_ready, 1'b1);
      chk("rst_fire", fire, 3'b000);
      chk("rst_active", active, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      chk_all();

      // Idle, then ch0 period 3
      run_to(102);
      load(2'd0, 8'd3);
      chk("rdy_load0", ld_ready, 1'b1);
      run_to(103);
      ld_valid = 1'b0;

      // Load held across a tick cycle
      run_to(209);
      load(2'd1, 8'd1);
      xbase = xfers;
      chk("rdy_on_tick", ld_ready, 1'b0);
      run_to(210);
      chk("rdy_after_tick", ld_ready, 1'b1);
      run_to(211);
      ld_valid = 1'b0;
      chk("one_xfer", xfers - xbase, 1);

      // ch2 period 2
      run_to(212);
      load(2'd2, 8'd2);
      run_to(213);
      ld_valid = 1'b0;

      // Disable everything
      run_to(300);
      load(2'd0, 8'd0);
      run_to(301);
      load(2'd1, 8'd0);
      run_to(302);
      load(2'd2, 8'd0);
      run_to(303);
      ld_valid = 1'b0;

      // Out-of-range channel: accepted, no effect
      run_to(305);
      load(2'd3, 8'd1);
      xbase = xfers;
      chk("rdy_oor", ld_ready, 1'b1);
      run_to(306);
      ld_valid = 1'b0;
      chk("oor_xfer", xfers - xbase, 1);

      // ch0 period 2, then reset in the middle of a fire pulse
      run_to(350);
      load(2'd0, 8'd2);
      run_to(351);
      ld_valid = 1'b0;
      run_to(390);
      #1;
      rst_n = 1'b0;
`ifdef TICK_SCHED_EXT_TICK_EN
      ext_tick = 1'b1;
`endif
      #1;
      chk("mid_rst_fire", fire, 3'b000);
      chk("mid_rst_active", active, 1'b0);
      chk("mid_rst_tick", tick, 1'b0);
      chk("mid_rst_ready", ld_ready, 1'b1);
`ifdef TICK_SCHED_EXT_TICK_EN
      ext_tick = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      epoch = 1;
      k = 0;
      chk_all();

      // Channels stay disabled until reloaded
      run_to(40);
      load(2'd0, 8'd1);
      chk("rdy_reload", ld_ready, 1'b1);
      run_to(41);
      ld_valid = 1'b0;
      run_to(62);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
